// File: rtl/systolic_feed_sequencer.sv
// systolic_feed_sequencer
// Feeds one GEMM tile into the systolic array. The weight rows go first. Then
// each input row goes in together with its partial-sum row. All rows come from
// a scratchpad read port that allows one outstanding request. After the last
// row the block waits for the array to drain, then pulses gemm_complete.
// Optional build macro: SEQ_PSUM_ZERO_EN adds cmd_zero_psum. When it is set,
// the partial-sum reads are skipped and zero partials are fed for that tile.
module systolic_feed_sequencer #(
   parameter int DIM = 4,
   parameter int DW  = 16,
   parameter int AW  = 10
) (
   input  logic                    CLK,
   input  logic                    nrst,
   input  logic                    cmd_valid,
   output logic                    cmd_ready,
   input  logic [AW-1:0]           cmd_w_base,
   input  logic [AW-1:0]           cmd_i_base,
   input  logic [AW-1:0]           cmd_p_base,
`ifdef SEQ_PSUM_ZERO_EN
   input  logic                    cmd_zero_psum,
`endif
   output logic                    sp_ren,
   output logic [AW-1:0]           sp_raddr,
   input  logic                    sp_rvalid,
   input  logic [DIM*DW-1:0]       sp_rdata,
   output logic                    weight_en,
   output logic                    input_en,
   output logic                    partial_en,
   output logic [$clog2(DIM)-1:0]  row_in_en,
   output logic [$clog2(DIM)-1:0]  row_ps_en,
   output logic [DIM*DW-1:0]       array_in,
   output logic [DIM*DW-1:0]       array_in_partials,
   input  logic                    fifo_has_space,
   input  logic                    drained,
   output logic                    busy,
   output logic                    gemm_complete
);

   localparam int RW  = $clog2(DIM);
   localparam int RDW = DIM * DW;

   // IP_WAIT holds an input/partial pair until the array FIFO has room.
   // The FIFO is checked the cycle before the IP_WR strobe. Because of this,
   // the strobes are decoded from state alone and no combinational path
   // exists from fifo_has_space to any output.
   typedef enum logic [3:0] {
      ST_IDLE    = 4'd0,
      ST_W_RD    = 4'd1,
      ST_W_WR    = 4'd2,
      ST_I_RD    = 4'd3,
      ST_P_RD    = 4'd4,
      ST_IP_WAIT = 4'd5,
      ST_IP_WR   = 4'd6,
      ST_DRAIN   = 4'd7,
      ST_DONE    = 4'd8
   } state_t;

   state_t          state_r, state_s;
   logic [RW-1:0]   row_r, row_s;
   logic [AW-1:0]   w_base_r, i_base_r, p_base_r;
   logic [RDW-1:0]  in_buf_r, ps_buf_r;
   logic            accept_s, last_row_s, ld_in_s, ld_ps_s, zero_s;

   assign accept_s   = cmd_valid & (state_r == ST_IDLE);
   assign last_row_s = (row_r == RW'(DIM - 1));

`ifdef SEQ_PSUM_ZERO_EN
   logic zero_r;

   // Zero-partials request, captured together with the command
   always_ff @(posedge CLK or negedge nrst) begin
      if (!nrst) begin
         zero_r <= 1'b0;
      end else if (accept_s) begin
         zero_r <= cmd_zero_psum;
      end
   end

   assign zero_s = zero_r;
`else
   assign zero_s = 1'b0;
`endif

   // State, row counter, latched command bases and operand row buffers
   always_ff @(posedge CLK or negedge nrst) begin
      if (!nrst) begin
         state_r  <= ST_IDLE;
         row_r    <= '0;
         w_base_r <= '0;
         i_base_r <= '0;
         p_base_r <= '0;
         in_buf_r <= '0;
         ps_buf_r <= '0;
      end else begin
         state_r <= state_s;
         row_r   <= row_s;
         if (accept_s) begin
            w_base_r <= cmd_w_base;
            i_base_r <= cmd_i_base;
            p_base_r <= cmd_p_base;
         end
         if (ld_in_s) begin
            in_buf_r <= sp_rdata;
         end
         if (ld_ps_s) begin
            ps_buf_r <= sp_rdata;
         end
      end
   end

   // Next-state, row advance and buffer capture decisions
   always_comb begin
      state_s = state_r;
      row_s   = row_r;
      ld_in_s = 1'b0;
      ld_ps_s = 1'b0;
      case (state_r)
         ST_IDLE: begin
            if (accept_s) begin
               state_s = ST_W_RD;
               row_s   = '0;
            end else begin
               state_s = ST_IDLE;
            end
         end
         ST_W_RD: begin
            if (sp_rvalid) begin
               ld_in_s = 1'b1;
               state_s = ST_W_WR;
            end else begin
               state_s = ST_W_RD;
            end
         end
         ST_W_WR: begin
            if (last_row_s) begin
               row_s   = '0;
               state_s = ST_I_RD;
            end else begin
               row_s   = row_r + RW'(1);
               state_s = ST_W_RD;
            end
         end
         ST_I_RD: begin
            if (sp_rvalid) begin
               ld_in_s = 1'b1;
               if (!zero_s) begin
                  state_s = ST_P_RD;
               end else if (fifo_has_space) begin
                  state_s = ST_IP_WR;
               end else begin
                  state_s = ST_IP_WAIT;
               end
            end else begin
               state_s = ST_I_RD;
            end
         end
         ST_P_RD: begin
            if (sp_rvalid) begin
               ld_ps_s = 1'b1;
               if (fifo_has_space) begin
                  state_s = ST_IP_WR;
               end else begin
                  state_s = ST_IP_WAIT;
               end
            end else begin
               state_s = ST_P_RD;
            end
         end
         ST_IP_WAIT: begin
            if (fifo_has_space) begin
               state_s = ST_IP_WR;
            end else begin
               state_s = ST_IP_WAIT;
            end
         end
         ST_IP_WR: begin
            if (last_row_s) begin
               state_s = ST_DRAIN;
            end else begin
               row_s   = row_r + RW'(1);
               state_s = ST_I_RD;
            end
         end
         ST_DRAIN: begin
            if (drained) begin
               state_s = ST_DONE;
            end else begin
               state_s = ST_DRAIN;
            end
         end
         ST_DONE: begin
            state_s = ST_IDLE;
         end
         default: begin
            state_s = ST_IDLE;
            row_s   = '0;
         end
      endcase
   end

   // Output decode from registered state, row counter and buffers only
   always_comb begin
      cmd_ready         = 1'b0;
      busy              = 1'b1;
      sp_ren            = 1'b0;
      sp_raddr          = '0;
      weight_en         = 1'b0;
      input_en          = 1'b0;
      partial_en        = 1'b0;
      row_in_en         = '0;
      row_ps_en         = '0;
      array_in          = '0;
      array_in_partials = '0;
      gemm_complete     = 1'b0;
      case (state_r)
         ST_IDLE: begin
            cmd_ready = 1'b1;
            busy      = 1'b0;
         end
         ST_W_RD: begin
            sp_ren   = 1'b1;
            sp_raddr = w_base_r + AW'(row_r);
         end
         ST_W_WR: begin
            weight_en = 1'b1;
            row_in_en = row_r;
            array_in  = in_buf_r;
         end
         ST_I_RD: begin
            sp_ren   = 1'b1;
            sp_raddr = i_base_r + AW'(row_r);
         end
         ST_P_RD: begin
            sp_ren   = 1'b1;
            sp_raddr = p_base_r + AW'(row_r);
         end
         ST_IP_WR: begin
            input_en   = 1'b1;
            partial_en = 1'b1;
            row_in_en  = row_r;
            row_ps_en  = row_r;
            array_in   = in_buf_r;
            if (zero_s) begin
               array_in_partials = '0;
            end else begin
               array_in_partials = ps_buf_r;
            end
         end
         ST_DONE: begin
            gemm_complete = 1'b1;
         end
         default: begin
            busy = 1'b1;
         end
      endcase
   end

endmodule
